// File: rtl/aq_axi_getfreq_sched.sv
// aq_axi_getfreq_sched: round-robin scheduler sequencing the shared frequency engine (clear, gate, settle, capture)
module aq_axi_getfreq_sched #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int CNT_W         = 32,
  parameter int CLEAR_CYCLES  = 4,
  parameter int GATE_CYCLES   = 100000000,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               AQ_LOCAL_CLK,
  input  logic               RST,
  input  logic               ENABLE,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic [NUM_REQ-1:0] DONE,
  output logic               BUSY,
  output logic [ID_W-1:0]    ENG_SEL,
  output logic               ENG_CLEAR,
  output logic               ENG_GATE,
  input  logic [CNT_W-1:0]   ENG_COUNT,
  input  logic               ENG_OVF,
  output logic [CNT_W-1:0]   RESULT,
  output logic [ID_W-1:0]    RESULT_ID,
  output logic               RESULT_OVF,
  output logic               RESULT_VALID
);
  localparam int MAXC = (CLEAR_CYCLES > GATE_CYCLES) ?
                        ((CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES) :
                        ((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES);
  localparam int TW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, CAPT} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [ID_W-1:0] ptr, off, pick;
  logic [ID_W:0] sum;
  logic [NUM_REQ-1:0] rot, sel_oh;
  logic grant, hold, expired;
  assign sel_oh  = NUM_REQ'(1) << ENG_SEL;
  assign hold    = |(REQ & sel_oh);
  assign expired = timer == '0;
  assign rot     = NUM_REQ'({REQ, REQ} >> ptr);
  // Lowest set bit of the rotated request vector is the first requester at or after ptr
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) off = ID_W'(i);
    sum  = {1'b0, ptr} + {1'b0, off};
    pick = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
  end
  always_comb begin
    state_n = state;
    timer_n = timer - TW'(1);
    grant   = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (ENABLE && |REQ) begin
          grant   = 1'b1;
          state_n = CLEAR;
          timer_n = TW'(CLEAR_CYCLES - 1);
        end
      end
      CLEAR: begin
        if (!hold) state_n = IDLE;
        else if (expired) begin
          state_n = GATE;
          timer_n = TW'(GATE_CYCLES - 1);
        end
      end
      GATE: begin
        if (!hold) state_n = IDLE;
        else if (expired) begin
          state_n = SETTLE;
          timer_n = TW'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: state_n = !hold ? IDLE : (expired ? CAPT : SETTLE);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge AQ_LOCAL_CLK) begin
    if (RST) begin
      state        <= IDLE;
      timer        <= '0;
      ptr          <= '0;
      ENG_SEL      <= '0;
      RESULT       <= '0;
      RESULT_ID    <= '0;
      RESULT_OVF   <= 1'b0;
      RESULT_VALID <= 1'b0;
      DONE         <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      RESULT_VALID <= state == CAPT;
      DONE         <= (state == CAPT) ? sel_oh : '0;
      if (grant) begin
        ENG_SEL <= pick;
        ptr     <= (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
      end
      if (state == CAPT) begin
        RESULT     <= ENG_COUNT;
        RESULT_OVF <= ENG_OVF;
        RESULT_ID  <= ENG_SEL;
      end
    end
  end
  assign GNT       = (state != IDLE) ? sel_oh : '0;
  assign BUSY      = state != IDLE;
  assign ENG_CLEAR = state == CLEAR;
  assign ENG_GATE  = state == GATE;
endmodule

// File: tb/tb_aq_axi_getfreq_sched.sv
// tb_aq_axi_getfreq_sched: randomized scenario bench with a cycle-position reference model of each job
module tb_aq_axi_getfreq_sched;
  logic clk = 1'b0, RST = 1'b1, ENABLE = 1'b0, ENG_OVF = 1'b0;
  logic [3:0] REQ = '0;
  logic [31:0] ENG_COUNT = '0;
  logic [3:0] GNT, DONE;
  logic BUSY, ENG_CLEAR, ENG_GATE, RESULT_OVF, RESULT_VALID;
  logic [1:0] ENG_SEL, RESULT_ID;
  logic [31:0] RESULT;
  int n_chk = 0, n_fail = 0, exp_ptr = 0;
  logic [31:0] exp_res = '0;
  logic [1:0] exp_id = '0;
  logic exp_ovf = 1'b0;

  aq_axi_getfreq_sched #(
    .NUM_REQ(4), .ID_W(2), .CNT_W(32),
    .CLEAR_CYCLES(2), .GATE_CYCLES(16), .SETTLE_CYCLES(3)
  ) dut (
    .AQ_LOCAL_CLK(clk), .RST(RST), .ENABLE(ENABLE), .REQ(REQ),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY), .ENG_SEL(ENG_SEL),
    .ENG_CLEAR(ENG_CLEAR), .ENG_GATE(ENG_GATE),
    .ENG_COUNT(ENG_COUNT), .ENG_OVF(ENG_OVF),
    .RESULT(RESULT), .RESULT_ID(RESULT_ID), .RESULT_OVF(RESULT_OVF), .RESULT_VALID(RESULT_VALID)
  );

  always #5 clk = ~clk;

  // Round-robin rule: first requester at or after the pointer, wrapping
  function automatic int pick_model(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  // Caller leaves REQ set before the next rising edge, which is the grant edge
  task automatic run_job(input bit jitter, input bit drop_en, input bit capt_drop, input bit force_ovf);
    int w;
    logic [3:0] oh, r;
    logic [31:0] cap;
    logic cap_ovf;
    logic [13:0] e;
    w = pick_model(REQ, exp_ptr);
    if (w < 0) return;
    exp_ptr = (w + 1) % 4;
    oh = 4'(1 << w);
    cap = '0;
    cap_ovf = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      e = {oh, 2'(w), c <= 2, c >= 3 && c <= 18, 1'b1, 1'b0, 4'b0};
      n_chk++;
      if ({GNT, ENG_SEL, ENG_CLEAR, ENG_GATE, BUSY, RESULT_VALID, DONE} !== e || RESULT !== exp_res) begin
        n_fail++;
        $display("FAIL job req%0d cycle %0d: {gnt,sel,clr,gate,busy,rv,done}=%b result=%h, expected %b result=%h",
                 w, c, {GNT, ENG_SEL, ENG_CLEAR, ENG_GATE, BUSY, RESULT_VALID, DONE}, RESULT, e, exp_res);
      end
      ENG_COUNT = $urandom;
      ENG_OVF = force_ovf | 1'($urandom);
      if (jitter) begin
        r = 4'($urandom);
        r[w] = 1'b1;
        REQ = r;
      end
      if (drop_en && c == 5) ENABLE = 1'b0;
      if (capt_drop && c == 22) REQ[w] = 1'b0;
      if (c == 22) begin
        cap = ENG_COUNT;
        cap_ovf = ENG_OVF;
      end
    end
    @(negedge clk);
    exp_res = cap;
    exp_id = 2'(w);
    exp_ovf = cap_ovf;
    n_chk++;
    if ({GNT, BUSY, ENG_CLEAR, ENG_GATE, RESULT_VALID, DONE} !== {4'b0, 3'b0, 1'b1, oh} ||
        RESULT !== exp_res || RESULT_ID !== exp_id || RESULT_OVF !== exp_ovf) begin
      n_fail++;
      $display("FAIL capture req%0d: gnt=%b busy=%b rv=%b done=%b result=%h id=%0d ovf=%b, expected gnt=0 busy=0 rv=1 done=%b result=%h id=%0d ovf=%b",
               w, GNT, BUSY, RESULT_VALID, DONE, RESULT, RESULT_ID, RESULT_OVF, oh, exp_res, exp_id, exp_ovf);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ENABLE = 1'b1;
    REQ = 4'hf;
    ENG_COUNT = $urandom;
    ENG_OVF = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({GNT, DONE, BUSY, ENG_SEL, ENG_CLEAR, ENG_GATE, RESULT, RESULT_ID, RESULT_OVF, RESULT_VALID} !== '0) begin
      n_fail++;
      $display("FAIL reset: gnt=%b done=%b busy=%b sel=%0d clr=%b gate=%b res=%h id=%0d ovf=%b rv=%b, all required 0",
               GNT, DONE, BUSY, ENG_SEL, ENG_CLEAR, ENG_GATE, RESULT, RESULT_ID, RESULT_OVF, RESULT_VALID);
    end
    RST = 1'b0;
    ENABLE = 1'b0;
    REQ = '0;
    exp_ptr = 0;
    exp_res = '0;
    exp_id = '0;
    exp_ovf = 1'b0;
  endtask

  task automatic test_idle(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_chk++;
      if ({GNT, BUSY, ENG_CLEAR, ENG_GATE, RESULT_VALID, DONE} !== '0 || RESULT !== exp_res ||
          RESULT_ID !== exp_id || RESULT_OVF !== exp_ovf) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: gnt=%b busy=%b clr=%b gate=%b rv=%b done=%b result=%h id=%0d ovf=%b, expected idle with result=%h id=%0d ovf=%b",
                 name, c, GNT, BUSY, ENG_CLEAR, ENG_GATE, RESULT_VALID, DONE, RESULT, RESULT_ID, RESULT_OVF, exp_res, exp_id, exp_ovf);
      end
    end
  endtask

  task automatic test_single();
    ENABLE = 1'b1;
    REQ = 4'b0001;
    run_job(0, 0, 0, 0);
    REQ = '0;
    test_idle("single", 2);
  endtask

  task automatic test_fairness();
    REQ = 4'hf;
    repeat (5) run_job(0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    REQ = 4'b0100;
    run_job(0, 0, 0, 0);
    REQ = 4'b0011;
    run_job(0, 0, 0, 0);
    run_job(0, 0, 0, 0);
    REQ = '0;
    test_idle("wrap", 1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      REQ = 4'($urandom_range(1, 15));
      run_job(1, 0, 0, 0);
    end
    REQ = '0;
    test_idle("random", 1);
  endtask

  task automatic test_abort();
    int ab[5] = '{7, 1, 2, 19, 21};
    int w;
    for (int k = 0; k < 5; k++) begin
      REQ = (k == 0) ? 4'b0110 : 4'($urandom_range(1, 15));
      w = pick_model(REQ, exp_ptr);
      exp_ptr = (w + 1) % 4;
      for (int c = 1; c <= ab[k]; c++) begin
        @(negedge clk);
        n_chk++;
        if (GNT !== 4'(1 << w) || ENG_SEL !== 2'(w)) begin
          n_fail++;
          $display("FAIL abort pre req%0d cycle %0d: gnt=%b sel=%0d, expected gnt=%b sel=%0d", w, c, GNT, ENG_SEL, 4'(1 << w), w);
        end
        ENG_COUNT = $urandom;
      end
      REQ[w] = 1'b0;
      test_idle("abort", 1);
      if (REQ != '0) run_job(0, 0, 0, 0);
      REQ = '0;
      test_idle("abort tail", 1);
    end
  endtask

  task automatic test_capt_drop();
    REQ = 4'($urandom_range(1, 15));
    run_job(0, 0, 1, 0);
    REQ = '0;
    test_idle("capt drop", 2);
  endtask

  task automatic test_enable();
    ENABLE = 1'b0;
    REQ = 4'hf;
    test_idle("enable low", 20);
    ENABLE = 1'b1;
    run_job(0, 1, 0, 0);
    test_idle("enable dropped", 20);
  endtask

  task automatic test_rst_mid();
    ENABLE = 1'b1;
    REQ = 4'hf;
    repeat (10) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({GNT, DONE, BUSY, ENG_SEL, ENG_CLEAR, ENG_GATE, RESULT, RESULT_ID, RESULT_OVF, RESULT_VALID} !== '0) begin
      n_fail++;
      $display("FAIL rst mid gate: gnt=%b done=%b busy=%b sel=%0d clr=%b gate=%b res=%h id=%0d ovf=%b rv=%b, all required 0",
               GNT, DONE, BUSY, ENG_SEL, ENG_CLEAR, ENG_GATE, RESULT, RESULT_ID, RESULT_OVF, RESULT_VALID);
    end
    RST = 1'b0;
    exp_ptr = 0;
    exp_res = '0;
    exp_id = '0;
    exp_ovf = 1'b0;
    run_job(0, 0, 0, 1);
    REQ = '0;
    test_idle("after ovf", 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_random();
    test_abort();
    test_capt_drop();
    test_enable();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
